// File: rtl/rr_req_encoder8_pkg.sv
// Shared constants and state encoding for the 8-line round-robin request encoder.
package rr_req_encoder8_pkg;

  localparam int N  = 8;
  localparam int IW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_req_encoder8_pick8.sv
// Combinational round-robin picker: first set request at or after Ptr, wrapping modulo 8.
module rr_pick8
  import rr_req_encoder8_pkg::*;
(
  input  logic [N-1:0]  Req,
  input  logic [IW-1:0] Ptr,
  output logic [IW-1:0] Idx,
  output logic          Any
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;

  always_comb begin
    // Rotating right by Ptr makes bit Ptr the highest-priority position (bit 0).
    rot = N'({Req, Req} >> Ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    Idx = off + Ptr;
    Any = |Req;
  end

endmodule

// File: rtl/rr_req_encoder8.sv
// Registered 8-to-3 round-robin request encoder with grant/done handshake.
//   state | meaning
//   IDLE  | no owner; grant issued on the next edge when En=1 and Req!=0
//   GRANT | W/Grant/Valid frozen until the owner pulses Done
module rr_req_encoder8
  import rr_req_encoder8_pkg::*;
(
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [N-1:0]  Req,
  input  logic          En,
  input  logic          Done,
  output logic [IW-1:0] W,
  output logic [N-1:0]  Grant,
  output logic          Valid
);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] w_q, w_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;

  rr_pick8 u_pick (
    .Req (Req),
    .Ptr (ptr_q),
    .Idx (pick_idx),
    .Any (pick_any)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    grant_d = grant_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (En && pick_any) begin
          w_d     = pick_idx;
          grant_d = N'(1) << pick_idx;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Release only; re-arbitration waits for a cycle in IDLE.
        if (Done) begin
          valid_d = 1'b0;
          grant_d = '0;
          ptr_d   = w_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign W     = w_q;
  assign Grant = grant_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_rr_req_encoder8.sv
// Directed-vector bench for the round-robin request encoder.
module tb_rr_req_encoder8;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [7:0] Req;
  logic       En;
  logic       Done;
  logic [2:0] W;
  logic [7:0] Grant;
  logic       Valid;

  int errors = 0;
  int checks = 0;

  rr_req_encoder8 dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Req    (Req),
    .En     (En),
    .Done   (Done),
    .W      (W),
    .Grant  (Grant),
    .Valid  (Valid)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Req = '0; En = 1'b0; Done = 1'b0;
    #3;
    checks++;
    if ({Valid, W, Grant} !== 12'h000) begin
      errors++;
      $display("FAIL reset_init: got Valid=%b W=%0d Grant=%b, want 0/0/0", Valid, W, Grant);
    end
    tick(); tick();
    Resetn = 1'b1;
    tick();
    checks++;
    if ({Valid, W, Grant} !== 12'h000) begin
      errors++;
      $display("FAIL reset_idle: got Valid=%b W=%0d Grant=%b, want 0/0/0", Valid, W, Grant);
    end
  endtask

  // Ptr=0: grant bit 2, then ignore Req changes while held.
  task automatic test_basic_grant();
    Req = 8'b0010_0100; En = 1'b1;
    tick();
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd2, 8'b0000_0100}) begin
      errors++;
      $display("FAIL basic_grant: got Valid=%b W=%0d Grant=%b, want 1/2/00000100", Valid, W, Grant);
    end
    Req = 8'h80;
    tick(); tick();
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd2, 8'b0000_0100}) begin
      errors++;
      $display("FAIL grant_hold_req: got Valid=%b W=%0d Grant=%b, want 1/2/00000100", Valid, W, Grant);
    end
  endtask

  task automatic test_rotate();
    Req = 8'b0010_0100; Done = 1'b1;
    tick();
    Done = 1'b0;
    checks++;
    if ({Valid, W, Grant} !== {1'b0, 3'd2, 8'h00}) begin
      errors++;
      $display("FAIL release: got Valid=%b W=%0d Grant=%b, want 0/2/0", Valid, W, Grant);
    end
    tick();
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd5, 8'b0010_0000}) begin
      errors++;
      $display("FAIL rotate_to_5: got Valid=%b W=%0d Grant=%b, want 1/5/00100000", Valid, W, Grant);
    end
    Done = 1'b1; tick(); Done = 1'b0;
    tick();
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd2, 8'b0000_0100}) begin
      errors++;
      $display("FAIL rotate_wrap_to_2: got Valid=%b W=%0d Grant=%b, want 1/2/00000100", Valid, W, Grant);
    end
    Done = 1'b1; tick(); Done = 1'b0;   // Ptr now 3
  endtask

  task automatic test_ptr_wrap();
    Req = 8'h40;
    tick();
    checks++;
    if ({Valid, W} !== {1'b1, 3'd6}) begin
      errors++;
      $display("FAIL grant_6: got Valid=%b W=%0d, want 1/6", Valid, W);
    end
    Done = 1'b1; tick(); Done = 1'b0;   // Ptr now 7
    Req = 8'b1000_0001;
    tick();
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd7, 8'h80}) begin
      errors++;
      $display("FAIL ptr7_grant: got Valid=%b W=%0d Grant=%b, want 1/7/10000000", Valid, W, Grant);
    end
    Done = 1'b1; tick(); Done = 1'b0;   // Ptr wraps to 0
    tick();
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd0, 8'h01}) begin
      errors++;
      $display("FAIL ptr_wrap_grant: got Valid=%b W=%0d Grant=%b, want 1/0/00000001", Valid, W, Grant);
    end
    Done = 1'b1; tick(); Done = 1'b0;   // Ptr now 1
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    En = 1'b0; Req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL en_low_no_grant: got %0d cycles with Valid=1, want 0", bad);
    end
    En = 1'b1;
    tick();
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd1, 8'h02}) begin
      errors++;
      $display("FAIL en_grant_1: got Valid=%b W=%0d Grant=%b, want 1/1/00000010", Valid, W, Grant);
    end
    En = 1'b0; Req = 8'h00;
    tick(); tick(); tick();
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd1, 8'h02}) begin
      errors++;
      $display("FAIL en_low_hold: got Valid=%b W=%0d Grant=%b, want 1/1/00000010", Valid, W, Grant);
    end
    Req = 8'hFF; Done = 1'b1;
    tick();
    Done = 1'b0;
    tick();
    checks++;
    if (Valid !== 1'b0) begin
      errors++;
      $display("FAIL en_low_after_done: got Valid=%b, want 0", Valid);
    end
  endtask

  // Ptr is 2 here; Done in IDLE must not move it.
  task automatic test_idle_done();
    En = 1'b1; Req = 8'h00; Done = 1'b1;
    tick();
    checks++;
    if ({Valid, Grant} !== 9'h000) begin
      errors++;
      $display("FAIL idle_done_noop: got Valid=%b Grant=%b, want 0/0", Valid, Grant);
    end
    Req = 8'b0000_0110;
    tick();
    Done = 1'b0;
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd2, 8'h04}) begin
      errors++;
      $display("FAIL req_with_done_idle: got Valid=%b W=%0d Grant=%b, want 1/2/00000100", Valid, W, Grant);
    end
    Done = 1'b1; tick(); Done = 1'b0;   // Ptr now 3
    checks++;
    if (Valid !== 1'b0) begin
      errors++;
      $display("FAIL no_same_edge_regrant: got Valid=%b, want 0", Valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    Req = 8'h20; En = 1'b1;
    tick();
    checks++;
    if ({Valid, W} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL pre_reset_grant: got Valid=%b W=%0d, want 1/5", Valid, W);
    end
    #2 Resetn = 1'b0;
    #1;
    checks++;
    if ({Valid, W, Grant} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got Valid=%b W=%0d Grant=%b, want 0/0/0", Valid, W, Grant);
    end
    tick();
    Resetn = 1'b1;
    Req = 8'h81;
    tick();
    checks++;
    if ({Valid, W, Grant} !== {1'b1, 3'd0, 8'h01}) begin
      errors++;
      $display("FAIL post_reset_grant: got Valid=%b W=%0d Grant=%b, want 1/0/00000001", Valid, W, Grant);
    end
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_rotate();
    test_ptr_wrap();
    test_enable();
    test_idle_done();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
